// File: rtl/div_pkg.sv
// Shared constants and state encoding for the 4-bit restoring divider.
package div_pkg;

  localparam int WIDTH = 4;
  localparam int STEPS = 4;
  localparam int CNT_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: trial subtract of the divisor from the shifted
// partial remainder, keeping the difference only when no borrow occurs.
module div_step
  import div_pkg::*;
(
  input  logic [WIDTH:0]   rem_shift,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic             q_bit
);

  // The extra top bit of the trial result is the borrow out of the 5-bit subtract.
  logic [WIDTH+1:0] trial;

  assign trial    = {1'b0, rem_shift} - {2'b00, divisor};
  assign q_bit    = ~trial[WIDTH+1];
  assign rem_next = trial[WIDTH+1] ? rem_shift : trial[WIDTH:0];

endmodule

// File: rtl/four_bit_sequential_divider.sv
// Multi-cycle unsigned restoring divider with a start/done handshake.
// Optional early divide-by-zero completion: define DIVIDER_DIVZERO_DETECT_EN.
module four_bit_sequential_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  import div_pkg::state_t;
  import div_pkg::ST_IDLE;
  import div_pkg::ST_RUN;
  import div_pkg::ST_DONE;
  import div_pkg::STEPS;
  import div_pkg::CNT_W;

  state_t state;
  state_t state_nxt;

  logic [CNT_W-1:0] step_cnt;
  logic [WIDTH-1:0] q_sr;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH:0]   r_reg;
  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_next;
  logic             q_bit;
  logic             accept;
  logic             last_step;
  logic             zero_div;
  logic             unused_r_msb;

  assign accept       = (state == ST_IDLE) && start;
  assign last_step    = (state == ST_RUN) && (step_cnt == CNT_W'(STEPS - 1));
  assign rem_shift    = {r_reg[WIDTH-1:0], q_sr[WIDTH-1]};
  // The partial remainder stays below the divisor, so its top bit never feeds the next step.
  assign unused_r_msb = r_reg[WIDTH];

`ifdef DIVIDER_DIVZERO_DETECT_EN
  assign zero_div = (divisor == '0);
`else
  assign zero_div = 1'b0;
`endif

  div_step u_step (
    .rem_shift (rem_shift),
    .divisor   (d_reg),
    .rem_next  (rem_next),
    .q_bit     (q_bit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = zero_div ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (last_step) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand capture, one shift/subtract per RUN cycle, result load on the final step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_cnt    <= '0;
      q_sr        <= '0;
      d_reg       <= '0;
      r_reg       <= '0;
      quotient_r  <= '0;
      remainder_r <= '0;
    end else if (accept) begin
      step_cnt <= '0;
      q_sr     <= dividend;
      d_reg    <= divisor;
      r_reg    <= '0;
      if (zero_div) begin
        quotient_r  <= '1;
        remainder_r <= dividend;
      end
    end else if (state == ST_RUN) begin
      step_cnt <= step_cnt + 1'b1;
      q_sr     <= {q_sr[WIDTH-2:0], q_bit};
      r_reg    <= rem_next;
      if (last_step) begin
        quotient_r  <= {q_sr[WIDTH-2:0], q_bit};
        remainder_r <= rem_next[WIDTH-1:0];
      end
    end
  end

`ifdef DIVIDER_DIVZERO_DETECT_EN
  logic div_zero_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_zero_r <= 1'b0;
    end else if (accept) begin
      div_zero_r <= zero_div;
    end
  end

  assign div_zero = div_zero_r;
`else
  assign div_zero = 1'b0;
`endif

  assign busy      = (state == ST_RUN) || (state == ST_DONE);
  assign done      = (state == ST_DONE);
  assign quotient  = quotient_r;
  assign remainder = remainder_r;

endmodule

// File: tb/tb_four_bit_sequential_divider.sv
// Scoreboard bench for four_bit_sequential_divider; honours DIVIDER_DIVZERO_DETECT_EN.
module tb_four_bit_sequential_divider;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_zero;

`ifdef DIVIDER_DIVZERO_DETECT_EN
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif

  typedef struct {
    logic [3:0] q;
    logic [3:0] r;
    logic       dz;
  } exp_t;

  exp_t sb[$];
  exp_t mon_exp;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  four_bit_sequential_divider #(.WIDTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic exp_t model(input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    if (b == 4'd0) begin
      e.q  = 4'hF;
      e.r  = a;
      e.dz = DZ_EN;
    end else begin
      e.q  = a / b;
      e.r  = a % b;
      e.dz = 1'b0;
    end
    return e;
  endfunction

  function automatic int latency(input logic [3:0] b);
    return (b == 4'd0 && DZ_EN) ? 1 : 5;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Scoreboard: every done pulse is matched against the oldest pending expectation.
  always @(negedge clk) begin
    if (!reset && done === 1'b1) begin
      if (sb.size() == 0) begin
        check_output("sb_pending", sb.size(), 1);
      end else begin
        mon_exp = sb.pop_front();
        check_output("quotient", quotient, mon_exp.q);
        check_output("remainder", remainder, mon_exp.r);
        check_output("div_zero", div_zero, mon_exp.dz);
      end
    end
  end

  // Called at a negedge; returns at the first IDLE negedge after done.
  task automatic apply_stimulus(input logic [3:0] a, input logic [3:0] b, input bit timing);
    int n;
    bit seen;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    sb.push_back(model(a, b));
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 4'($urandom);
    divisor  = 4'($urandom);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (timing) check_output("busy_run", busy, 1);
      if (done) seen = 1'b1;
    end
    check_output("done_seen", seen, 1);
    if (timing) check_output("latency", n, latency(b));
    @(negedge clk);
    if (timing) begin
      check_output("done_pulse", done, 0);
      check_output("busy_drop", busy, 0);
    end
  endtask

  task automatic wait_done(input string tag);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (done) seen = 1'b1;
    end
    check_output(tag, seen, 1);
  endtask

  initial begin
    int t1;
    int t2;
    int n;
    reset    = 1'b1;
    start    = 1'b0;
    dividend = 4'd0;
    divisor  = 4'd0;
    repeat (2) @(negedge clk);
    check_output("rst_busy", busy, 0);
    check_output("rst_done", done, 0);
    check_output("rst_quotient", quotient, 0);
    check_output("rst_remainder", remainder, 0);
    check_output("rst_div_zero", div_zero, 0);
    reset = 1'b0;
    @(negedge clk);

    apply_stimulus(4'd13, 4'd3, 1'b1);
    apply_stimulus(4'd15, 4'd1, 1'b1);
    apply_stimulus(4'd7, 4'd9, 1'b1);
    apply_stimulus(4'd0, 4'd5, 1'b1);
    apply_stimulus(4'd6, 4'd0, 1'b1);

    // A start raised mid-run must neither disturb the result nor queue a second division.
    dividend = 4'd13;
    divisor  = 4'd3;
    start    = 1'b1;
    sb.push_back(model(4'd13, 4'd3));
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    dividend = 4'd2;
    divisor  = 4'd2;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("busy_start_done");
    repeat (2) @(negedge clk);
    check_output("no_queue_busy", busy, 0);
    apply_stimulus(4'd2, 4'd2, 1'b1);

    // Asynchronous reset two cycles into 9/2 clears the previous 2/2 result.
    dividend = 4'd9;
    divisor  = 4'd2;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_output("abort_busy", busy, 0);
    check_output("abort_done", done, 0);
    check_output("abort_quotient", quotient, 0);
    check_output("abort_remainder", remainder, 0);
    check_output("abort_div_zero", div_zero, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    apply_stimulus(4'd9, 4'd2, 1'b1);

    // Start held high launches a new division every 6 cycles.
    dividend = 4'd8;
    divisor  = 4'd3;
    start    = 1'b1;
    sb.push_back(model(4'd8, 4'd3));
    sb.push_back(model(4'd8, 4'd3));
    t1 = -1;
    t2 = -1;
    n  = 0;
    while (t2 < 0 && n < 40) begin
      @(negedge clk);
      n++;
      if (done) begin
        if (t1 < 0) t1 = cyc;
        else t2 = cyc;
      end
    end
    start = 1'b0;
    check_output("held_interval", t2 - t1, 6);
    @(negedge clk);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        apply_stimulus(4'(a), 4'(b), 1'b0);
      end
    end

    repeat (3) @(negedge clk);
    check_output("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
